// File: rtl/riscv_ctrl_pkg.sv
// Shared types, opcode constants and control-field encodings for the multicycle RV32I controller.
package riscv_ctrl_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned IMM_W    = 3;
    localparam int unsigned ALU_W    = 3;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_LUI,
        S_AUIPC,
        S_ILLEGAL
    } state_t;

    typedef enum logic [IMM_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_t;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alucontrol_t;

    typedef enum logic [SEL_W-1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } resultsrc_t;

    typedef enum logic [SEL_W-1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } alusrca_t;

    typedef enum logic [SEL_W-1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alusrcb_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    // Immediate format is a pure function of the opcode, independent of FSM state.
    function automatic immsrc_t immsrc_decode(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memory (slave).
interface multicycle_controller_if;
    import riscv_ctrl_pkg::*;

    logic [OP_W-1:0]     op;
    logic [FUNCT3_W-1:0] funct3;
    logic                funct7b5;
    logic                zero;
    logic                mem_ready;

    logic                mem_req;
    logic                memwrite;
    logic                adrsrc;
    logic                irwrite;
    logic                pcwrite;
    logic                regwrite;
    logic [SEL_W-1:0]    resultsrc;
    logic [SEL_W-1:0]    alusrca;
    logic [SEL_W-1:0]    alusrcb;
    logic [ALU_W-1:0]    alucontrol;
    logic [IMM_W-1:0]    immsrc;
    logic                illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
               resultsrc, alusrca, alusrcb, alucontrol, immsrc, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
               resultsrc, alusrca, alusrcb, alucontrol, immsrc, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's ALU op class plus instruction function fields to an ALU control code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t              aluop,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                op5,
    input  logic                funct7b5,
    output logic [ALU_W-1:0]    alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // I-type has op[5]=0, so addi never turns into a subtract.
                    3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing ALU, register file, IR and unified memory for the multicycle RV32I core.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    aluop_t           aluop;
    logic [ALU_W-1:0] alucontrol;
    logic             mem_req;
    logic             memwrite;
    logic             adrsrc;
    logic             irwrite;
    logic             pcwrite;
    logic             regwrite;
    logic             illegal;
    resultsrc_t       resultsrc;
    alusrca_t         alusrca;
    alusrcb_t         alusrcb;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (alucontrol)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next state and per-state control outputs.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        memwrite  = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        regwrite  = 1'b0;
        illegal   = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RD2;
        aluop     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                irwrite   = bus.mem_ready;
                pcwrite   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch/jump target into ALUOut.
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = SRCA_RD1;
                alusrcb = SRCB_IMM;
                state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req   = 1'b1;
                adrsrc    = 1'b1;
                resultsrc = RES_ALUOUT;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                adrsrc   = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alusrca = SRCA_RD1;
                alusrcb = SRCB_RD2;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca = SRCA_RD1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                resultsrc = RES_ALUOUT;
                regwrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                // funct3[0] distinguishes bne from beq.
                alusrca   = SRCA_RD1;
                alusrcb   = SRCB_RD2;
                aluop     = ALUOP_SUB;
                resultsrc = RES_ALUOUT;
                pcwrite   = bus.zero ^ bus.funct3[0];
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alusrca   = SRCA_OLDPC;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALUOUT;
                pcwrite   = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alusrca = SRCA_ZERO;
                alusrcb = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_ILLEGAL;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every side effect immediately, not just from the next edge.
        if (reset) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign bus.mem_req    = mem_req;
    assign bus.memwrite   = memwrite;
    assign bus.adrsrc     = adrsrc;
    assign bus.irwrite    = irwrite;
    assign bus.pcwrite    = pcwrite;
    assign bus.regwrite   = regwrite;
    assign bus.resultsrc  = resultsrc;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.alucontrol = alucontrol;
    assign bus.immsrc     = immsrc_decode(bus.op);
    assign bus.illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction-level model of the expected control sequence.
`timescale 1ns/1ps
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [2:0] immsrc;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t o;
        int   waitable; // 0: never stalls, 1: fetch (write enables need ready), 2: data access
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int    checks = 0;
    int    errors = 0;
    obs_t  exp_q;
    logic  exp_valid = 1'b0;
    string tag = "";
    step_t plan_q[$];

    logic [6:0] i_op = 7'd0;
    logic [2:0] i_f3 = 3'd0;
    logic       i_f7 = 1'b0;
    logic       i_zero = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.mem_req    = bus.mem_req;
        o.memwrite   = bus.memwrite;
        o.adrsrc     = bus.adrsrc;
        o.irwrite    = bus.irwrite;
        o.pcwrite    = bus.pcwrite;
        o.regwrite   = bus.regwrite;
        o.resultsrc  = bus.resultsrc;
        o.alusrca    = bus.alusrca;
        o.alusrcb    = bus.alusrcb;
        o.alucontrol = bus.alucontrol;
        o.immsrc     = bus.immsrc;
        o.illegal    = bus.illegal;
        return o;
    endfunction

    // Single compare process: every cycle with a valid expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (exp_valid) check(tag, 32'(observe()), 32'(exp_q));
    end

    // Model: immediate format from opcode.
    function automatic logic [2:0] m_imm(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    // Model: ALU operation named by the instruction's function fields.
    function automatic logic [2:0] m_alu(input logic is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // en = {mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite}
    function automatic obs_t rec(input logic [5:0] en, input logic [1:0] res, input logic [1:0] a,
                                 input logic [1:0] b, input logic [2:0] alu, input logic ill);
        obs_t o;
        {o.mem_req, o.memwrite, o.adrsrc, o.irwrite, o.pcwrite, o.regwrite} = en;
        o.resultsrc  = res;
        o.alusrca    = a;
        o.alusrcb    = b;
        o.alucontrol = alu;
        o.immsrc     = 3'b000;
        o.illegal    = ill;
        return o;
    endfunction

    function automatic void push(input obs_t o, input int w);
        step_t s;
        s.o = o;
        s.waitable = w;
        plan_q.push_back(s);
    endfunction

    // Per-instruction control sequence with zero wait states.
    function automatic void build_plan(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        obs_t wb;
        wb = rec(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
        plan_q.delete();
        push(rec(6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0), 1);
        push(rec(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0), 0);
        case (op)
            7'b0000011: begin
                push(rec(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0), 0);
                push(rec(6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 2);
                push(rec(6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0), 0);
            end
            7'b0100011: begin
                push(rec(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0), 0);
                push(rec(6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 2);
            end
            7'b0110011: begin
                push(rec(6'b000000, 2'b00, 2'b10, 2'b00, m_alu(1'b1, f3, f7), 1'b0), 0);
                push(wb, 0);
            end
            7'b0010011: begin
                push(rec(6'b000000, 2'b00, 2'b10, 2'b01, m_alu(1'b0, f3, f7), 1'b0), 0);
                push(wb, 0);
            end
            7'b1100011:
                push(rec({4'b0000, z ^ f3[0], 1'b0}, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0), 0);
            7'b1101111: begin
                push(rec(6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0), 0);
                push(wb, 0);
            end
            7'b0110111: begin
                push(rec(6'b000000, 2'b00, 2'b11, 2'b01, 3'b000, 1'b0), 0);
                push(wb, 0);
            end
            7'b0010111: begin
                push(rec(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0), 0);
                push(wb, 0);
            end
            default:
                for (int i = 0; i < 4; i++) push(rec(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1), 0);
        endcase
    endfunction

    function automatic obs_t rst_rec();
        return rec(6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
    endfunction

    // Drive one cycle's inputs just after the rising edge and publish the expectation.
    task automatic step(input obs_t e, input logic rdy, input logic rst, input string t);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.mem_ready = rdy;
        bus.op        = i_op;
        bus.funct3    = i_f3;
        bus.funct7b5  = i_f7;
        bus.zero      = i_zero;
        e.immsrc      = m_imm(i_op);
        exp_q         = e;
        tag           = t;
        exp_valid     = 1'b1;
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fwait, input int mwait, input int exp_len);
        obs_t s;
        i_op = op; i_f3 = f3; i_f7 = f7; i_zero = z;
        build_plan(op, f3, f7, z);
        check({name, " cycles"}, 32'(plan_q.size()), 32'(exp_len));
        for (int k = 0; k < plan_q.size(); k++) begin
            int nw;
            nw = (plan_q[k].waitable == 1) ? fwait : (plan_q[k].waitable == 2) ? mwait : 0;
            for (int w = 0; w < nw; w++) begin
                s = plan_q[k].o;
                if (plan_q[k].waitable == 1) begin
                    s.irwrite = 1'b0;
                    s.pcwrite = 1'b0;
                end
                step(s, 1'b0, 1'b0, $sformatf("%s step%0d wait%0d", name, k, w));
            end
            step(plan_q[k].o, 1'b1, 1'b0, $sformatf("%s step%0d", name, k));
        end
    endtask

    initial begin
        obs_t fstall;
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        step(rst_rec(), 1'b1, 1'b1, "reset0");
        step(rst_rec(), 1'b1, 1'b1, "reset1");

        // Reset asserted while a store is waiting on memory.
        i_op = 7'b0100011; i_f3 = 3'b010; i_f7 = 1'b0; i_zero = 1'b0;
        build_plan(i_op, i_f3, i_f7, i_zero);
        step(plan_q[0].o, 1'b1, 1'b0, "rst_sw fetch");
        step(plan_q[1].o, 1'b1, 1'b0, "rst_sw decode");
        step(plan_q[2].o, 1'b1, 1'b0, "rst_sw memadr");
        step(plan_q[3].o, 1'b0, 1'b0, "rst_sw memwrite");
        #1 check("rst_sw memwrite before reset", 32'(bus.memwrite), 32'd1);
        step(rst_rec(), 1'b0, 1'b1, "rst_sw in reset");
        #1 check("rst_sw mem_req in reset", 32'(bus.mem_req), 32'd0);
        check("rst_sw memwrite in reset", 32'(bus.memwrite), 32'd0);
        step(rst_rec(), 1'b0, 1'b1, "rst_sw reset hold");
        fstall = plan_q[0].o;
        fstall.irwrite = 1'b0;
        fstall.pcwrite = 1'b0;
        step(fstall, 1'b0, 1'b0, "rst_sw fetch after release");
        #1 check("rst_sw mem_req after release", 32'(bus.mem_req), 32'd1);
        check("rst_sw irwrite after release", 32'(bus.irwrite), 32'd0);

        run_instr("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 5);
        run_instr("sw_wait",  7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, 4);
        run_instr("sub",      7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4);
        run_instr("add",      7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        run_instr("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4);
        run_instr("slt",      7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, 4);
        run_instr("ori",      7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 4);
        run_instr("and",      7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 4);
        run_instr("beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3);
        run_instr("beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3);
        run_instr("bne_z1",   7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 3);
        run_instr("bne_z0",   7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 3);
        run_instr("jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        run_instr("lui",      7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        run_instr("auipc",    7'b0010111, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        run_instr("lw_wait",  7'b0000011, 3'b010, 1'b0, 1'b0, 2, 1, 5);
        run_instr("illegal",  7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 6);
        #1 check("illegal flag sticky", 32'(bus.illegal), 32'd1);

        step(rst_rec(), 1'b1, 1'b1, "illegal reset");
        #1 check("illegal cleared by reset", 32'(bus.illegal), 32'd0);
        run_instr("addi_after", 7'b0010011, 3'b111, 1'b0, 1'b0, 1, 0, 4);

        @(posedge clk);
        #1 exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle RV32I core. It sequences the shared ALU, register file, instruction register and unified memory over several cycles per instruction. It also drives the select code for the immediate extender. Memory accesses use a req/ready handshake, so any memory latency is tolerated.

Parameters:
None.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; one clock; state register cleared to FETCH immediately
op  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
mem_req  out  1  memory access request
memwrite  out  1  write strobe (valid with mem_req)
adrsrc  out  1  0 = PC, 1 = ALUOut as memory address
irwrite  out  1  load instruction register
pcwrite  out  1  load PC
regwrite  out  1  register file write
resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
alusrca  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
alusrcb  out  2  00 RD2, 01 ImmExt, 10 constant 4
alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal  out  1  sticky unsupported-opcode flag

Behaviour:
- Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, LUI, AUIPC, ILLEGAL.
- Reset value is FETCH.
- While reset is high, mem_req, memwrite, irwrite, pcwrite and regwrite are forced to 0 and illegal is 0.
- Defaults: all enables 0, selects 00, alucontrol 000, illegal 0.
- ALU op classes:
  - add class gives alucontrol 000.
  - sub class gives alucontrol 001.
  - funct class decodes as follows:
    - funct3 000: 001 if op[5] and funct7b5, else 000.
    - funct3 010: 101.
    - funct3 110: 011.
    - funct3 111: 010.
    - Any other funct3: 000.
- FETCH: mem_req=1, adrsrc=0, alusrcb=10, resultsrc=10, add class.
  - irwrite=pcwrite=mem_ready.
  - Moves to DECODE only when mem_ready=1; otherwise holds.
- DECODE: alusrca=01, alusrcb=01, add class (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other op → ILLEGAL
- MEMADR: alusrca=10, alusrcb=01, add class. Next state is MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. Holds until mem_ready, then MEMWB.
- MEMWB: resultsrc=01, regwrite=1, then FETCH.
- MEMWRITE: mem_req=1, memwrite=1, adrsrc=1. Holds until mem_ready, then FETCH.
- EXECUTER: alusrca=10, alusrcb=00, funct class, then ALUWB.
- EXECUTEI: alusrca=10, alusrcb=01, funct class, then ALUWB. op[5]=0, so funct3 000 always adds.
- ALUWB: resultsrc=00, regwrite=1, then FETCH.
- BEQ: alusrca=10, alusrcb=00, sub class, resultsrc=00.
  - pcwrite = zero XOR funct3[0], covering beq (000) and bne (001).
  - Then FETCH.
- JAL: alusrca=01, alusrcb=10, add class, resultsrc=00, pcwrite=1, then ALUWB.
- LUI: alusrca=11, alusrcb=01, add class, then ALUWB.
- AUIPC: alusrca=01, alusrcb=01, add class, then ALUWB.
- ILLEGAL: illegal=1, all enables 0. Absorbing until reset.
- immsrc is combinational from op in every state:
  - S for 0100011
  - B for 1100011
  - J for 1101111
  - U for 0110111 and 0010111
  - I otherwise
- Cycle counts with zero wait states:
  - lw: 5
  - sw, R-type, I-type, jal, lui, auipc: 4
  - branch: 3
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored in all other states.
- Reset asserted mid-instruction: no further enable pulses; the FSM restarts at FETCH after deassertion.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - immsrc, alucontrol, resultsrc, alusrca and alusrcb encodings
  - op-class enum (add/sub/funct)
- One combinational sub-module, alu_decoder (op class, funct3, op[5], funct7b5 → alucontrol). The FSM and output decode stay in multicycle_controller.

Test Plan:
1. Reset asserted mid-MEMWRITE (mem_req=1) → mem_req/memwrite drop to 0 in the same cycle; after release, the state is FETCH, mem_req=1, irwrite=0.
2. lw (op 0000011) with mem_ready=1 always → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite only in cycle 5, resultsrc=01; immsrc=000.
3. sw (0100011) with mem_ready low 3 cycles in MEMWRITE → memwrite=1 held 4 cycles; returns to FETCH after the ready cycle; immsrc=001; regwrite never set.
4. R-type sub (funct3 000, funct7b5=1) → alucontrol 001 in EXECUTER; add (funct7b5=0) → 000; I-type addi with funct7b5=1 → 000; slt → 101.
5. beq with zero=1 → pcwrite=1 in BEQ; zero=0 → 0; bne (funct3 001) inverts both; immsrc=010; 3 cycles each.
6. jal → pcwrite in JAL, regwrite in ALUWB, immsrc=011. lui → alusrca=11, immsrc=100. op 1111111 → illegal=1 sticky, no enables until reset.
